// File: rtl/virtual_address_sequencer.sv
// Arbitrates the CPU virtual address register between fetch, load/store and MMU readback,
// pulses the VA register load for one cycle, then runs the MMU/bus access for fetch/data.
module virtual_address_sequencer #(
  parameter int unsigned         TimeoutCycles = 255,
  parameter int unsigned         TimeoutWidth  = 8,
  parameter int unsigned         SrcWidth      = 2,
  parameter logic [SrcWidth-1:0] SrcPc         = SrcWidth'(0),
  parameter logic [SrcWidth-1:0] SrcAddr       = SrcWidth'(1),
  parameter logic [SrcWidth-1:0] SrcMmu        = SrcWidth'(2)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                fetch_request_i,
  input  logic                data_request_i,
  input  logic                data_write_i,
  input  logic                mmu_request_i,
  output logic                va_write_enable_o,
  output logic [SrcWidth-1:0] va_write_data_source_o,
  output logic                bus_request_o,
  output logic                bus_write_o,
  input  logic                bus_acknowledge_i,
  input  logic                bus_fault_i,
  output logic                busy_o,
  output logic [1:0]          grant_o,
  output logic                fetch_done_o,
  output logic                data_done_o,
  output logic                mmu_done_o,
  output logic                fault_o,
  output logic                fault_timeout_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StAccess, StComplete} state_e;

  localparam logic [1:0] GrantNone  = 2'd0;
  localparam logic [1:0] GrantFetch = 2'd1;
  localparam logic [1:0] GrantData  = 2'd2;
  localparam logic [1:0] GrantMmu   = 2'd3;

  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [TimeoutWidth-1:0] TimeoutLast =
      TimeoutWidth'((TimeoutCycles == 0) ? 32'd0 : TimeoutCycles - 32'd1);

  state_e                  state_q, state_d;
  logic [1:0]              grant_q, grant_d;
  logic                    write_q, write_d;
  logic [TimeoutWidth-1:0] count_q, count_d;
  logic                    fault_q, fault_d;
  logic                    timeout_q, timeout_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      grant_q   <= GrantNone;
      write_q   <= 1'b0;
      count_q   <= '0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      write_q   <= write_d;
      count_q   <= count_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    grant_d                = grant_q;
    write_d                = write_q;
    count_d                = count_q;
    fault_d                = fault_q;
    timeout_d              = timeout_q;
    va_write_enable_o      = 1'b0;
    va_write_data_source_o = SrcPc;
    bus_request_o          = 1'b0;
    bus_write_o            = 1'b0;
    fetch_done_o           = 1'b0;
    data_done_o            = 1'b0;
    mmu_done_o             = 1'b0;
    fault_o                = 1'b0;
    fault_timeout_o        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Fixed priority: mmu > data > fetch.
        if (mmu_request_i) begin
          grant_d = GrantMmu;
          write_d = 1'b0;
          state_d = StLoad;
        end else if (data_request_i) begin
          grant_d = GrantData;
          write_d = data_write_i;
          state_d = StLoad;
        end else if (fetch_request_i) begin
          grant_d = GrantFetch;
          write_d = 1'b0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        va_write_enable_o = 1'b1;
        case (grant_q)
          GrantData: va_write_data_source_o = SrcAddr;
          GrantMmu:  va_write_data_source_o = SrcMmu;
          default:   va_write_data_source_o = SrcPc;
        endcase
        count_d   = '0;
        fault_d   = 1'b0;
        timeout_d = 1'b0;
        state_d   = (grant_q == GrantMmu) ? StComplete : StAccess;
      end
      StAccess: begin
        bus_request_o = 1'b1;
        bus_write_o   = write_q;
        if (count_q != {TimeoutWidth{1'b1}}) count_d = count_q + 1'b1;
        // A fault outranks a simultaneous acknowledge.
        if (bus_fault_i) begin
          fault_d = 1'b1;
          state_d = StComplete;
        end else if (bus_acknowledge_i) begin
          state_d = StComplete;
        end else if (TimeoutEn && (count_q == TimeoutLast)) begin
          fault_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = StComplete;
        end
      end
      StComplete: begin
        if (fault_q) begin
          fault_o         = 1'b1;
          fault_timeout_o = timeout_q;
        end else begin
          fetch_done_o = (grant_q == GrantFetch);
          data_done_o  = (grant_q == GrantData);
          mmu_done_o   = (grant_q == GrantMmu);
        end
        grant_d = GrantNone;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o  = (state_q != StIdle);
  assign grant_o = grant_q;

endmodule

// File: tb/tb_virtual_address_sequencer.sv
// Directed and randomized bench for virtual_address_sequencer, with an external VA register
// and a transaction-level model of arbitration order, bus timing and completion outcome.
module tb_virtual_address_sequencer;

  localparam int unsigned Tmo = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0, data_req = 1'b0, data_write = 1'b0, mmu_req = 1'b0;
  logic        bus_ack = 1'b0, bus_fault = 1'b0;
  logic        va_we, bus_req, bus_write, busy;
  logic [1:0]  va_src, grant;
  logic        fetch_done, data_done, mmu_done, fault, fault_to;
  logic [31:0] pc = 32'h0, addr = 32'h0, mmu_data = 32'h0, va_q = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  virtual_address_sequencer #(
    .TimeoutCycles(Tmo),
    .TimeoutWidth (8)
  ) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_n),
    .fetch_request_i       (fetch_req),
    .data_request_i        (data_req),
    .data_write_i          (data_write),
    .mmu_request_i         (mmu_req),
    .va_write_enable_o     (va_we),
    .va_write_data_source_o(va_src),
    .bus_request_o         (bus_req),
    .bus_write_o           (bus_write),
    .bus_acknowledge_i     (bus_ack),
    .bus_fault_i           (bus_fault),
    .busy_o                (busy),
    .grant_o               (grant),
    .fetch_done_o          (fetch_done),
    .data_done_o           (data_done),
    .mmu_done_o            (mmu_done),
    .fault_o               (fault),
    .fault_timeout_o       (fault_to)
  );

  always #5 clk = ~clk;

  // Stand-in for the VirtualAddressRegister the sequencer drives.
  always @(posedge clk) begin
    if (va_we) begin
      case (va_src)
        2'd0:    va_q <= pc;
        2'd1:    va_q <= addr;
        2'd2:    va_q <= mmu_data;
        default: va_q <= 32'hxxxx_xxxx;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_outs"}, 32'({va_we, bus_req, bus_write, fetch_done, data_done, mmu_done,
                             fault, fault_to}), 0);
    chk({tag, "_src"}, 32'(va_src), 0);
  endtask

  // Serves one grant g (1 fetch, 2 data, 3 mmu). delay = ACCESS cycles before the bus
  // responds (>= Tmo means never); flt makes that response a fault. Returns the number of
  // falling edges from call to the completion cycle, leaving the bench in that cycle.
  task automatic serve(input logic [1:0] g, input int delay, input bit flt, input bit dw,
                       output int cyc);
    int          n;
    int          bus_cycles;
    int          exp_cycles;
    bit          exp_to, exp_fault;
    logic [31:0] exp_va;
    logic [1:0]  exp_src;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!va_we && n < 10);
    cyc     = n;
    exp_src = (g == 2'd3) ? 2'd2 : (g == 2'd2) ? 2'd1 : 2'd0;
    exp_va  = (g == 2'd3) ? mmu_data : (g == 2'd2) ? addr : pc;
    chk("load_we", 32'(va_we), 1);
    chk("load_grant", 32'(grant), 32'(g));
    chk("load_src", 32'(va_src), 32'(exp_src));
    chk("load_busreq", 32'(bus_req), 0);
    if (g == 2'd2) data_write = ~dw;  // must be ignored after grant
    @(negedge clk);
    cyc++;
    chk("va_value", va_q, exp_va);
    exp_to    = (g != 2'd3) && (delay >= int'(Tmo));
    exp_fault = exp_to || ((g != 2'd3) && flt);
    if (g != 2'd3) begin
      bus_cycles = 0;
      while (bus_req && bus_cycles < 40) begin
        if (bus_cycles == 0) chk("bus_write", 32'(bus_write), 32'(dw));
        if (bus_cycles == delay) begin
          bus_ack   = flt ? 1'($urandom_range(0, 1)) : 1'b1;
          bus_fault = flt;
        end
        bus_cycles++;
        @(negedge clk);
        cyc++;
        bus_ack   = 1'b0;
        bus_fault = 1'b0;
      end
      exp_cycles = (delay < int'(Tmo)) ? delay + 1 : int'(Tmo);
      chk("bus_cycles", 32'(bus_cycles), 32'(exp_cycles));
    end
    chk("cpl_busy", 32'(busy), 1);
    chk("cpl_grant", 32'(grant), 32'(g));
    chk("cpl_fetch_done", 32'(fetch_done), 32'(g == 2'd1 && !exp_fault));
    chk("cpl_data_done", 32'(data_done), 32'(g == 2'd2 && !exp_fault));
    chk("cpl_mmu_done", 32'(mmu_done), 32'(g == 2'd3));
    chk("cpl_fault", 32'(fault), 32'(exp_fault));
    chk("cpl_fault_to", 32'(fault_to), 32'(exp_to));
    case (g)
      2'd1:    fetch_req = 1'b0;
      2'd2:    data_req = 1'b0;
      default: mmu_req = 1'b0;
    endcase
  endtask

  initial begin
    int          cyc;
    int          n;
    bit          seen;
    logic [31:0] va_hold;

    // Reset state
    #1;
    chk_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Fetch with immediate ack: done on the third cycle
    pc = 32'h1234_5678;
    fetch_req = 1'b1;
    serve(2'd1, 0, 1'b0, 1'b0, cyc);
    chk("fetch_latency", 32'(cyc), 3);
    @(negedge clk);
    chk_quiet("fetch_idle");

    // All three together: mmu, data, fetch
    mmu_data = 32'hea00_ea00;
    addr     = 32'hdefd_efde;
    pc       = 32'h0bad_f00d;
    data_write = 1'b0;
    {fetch_req, data_req, mmu_req} = 3'b111;
    serve(2'd3, 0, 1'b0, 1'b0, cyc);
    chk("mmu_latency", 32'(cyc), 2);
    serve(2'd2, 1, 1'b0, 1'b0, cyc);
    serve(2'd1, 2, 1'b0, 1'b0, cyc);
    @(negedge clk);
    chk_quiet("triple_idle");

    // Store acknowledged after 5 wait cycles (last cycle before timeout)
    addr = 32'h0000_4440;
    data_write = 1'b1;
    data_req = 1'b1;
    serve(2'd2, 5, 1'b0, 1'b1, cyc);
    @(negedge clk);

    // Timeout, then simultaneous fault and ack
    data_write = 1'b0;
    data_req = 1'b1;
    serve(2'd2, 99, 1'b0, 1'b0, cyc);
    @(negedge clk);
    fetch_req = 1'b1;
    serve(2'd1, 2, 1'b1, 1'b0, cyc);
    @(negedge clk);

    // Asynchronous reset in the middle of an access
    data_req = 1'b1;
    n = 0;
    while (!bus_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("pre_reset_busreq", 32'(bus_req), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busreq", 32'(bus_req), 0);
    chk("async_busy", 32'(busy), 0);
    data_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (fetch_done | data_done | mmu_done | fault | busy) seen = 1'b1;
    end
    chk("no_pulse_after_reset", 32'(seen), 0);
    chk_quiet("after_reset");

    // Idle hold: VA frozen while PC wanders
    pc = 32'h5555_aaaa;
    fetch_req = 1'b1;
    serve(2'd1, 0, 1'b0, 1'b0, cyc);
    @(negedge clk);
    va_hold = va_q;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pc = $urandom;
      @(negedge clk);
      if (va_we || va_q !== va_hold) seen = 1'b1;
    end
    chk("idle_va_frozen", 32'(seen), 0);
    chk("idle_va_value", va_q, 32'h5555_aaaa);

    // Randomized rounds: served in priority order with random bus behaviour
    for (int r = 0; r < 20; r++) begin
      logic [2:0] set;
      bit         dw;
      set = 3'($urandom_range(1, 7));
      dw  = 1'($urandom_range(0, 1));
      pc = $urandom;
      addr = $urandom;
      mmu_data = $urandom;
      data_write = dw;
      {mmu_req, data_req, fetch_req} = set;
      for (int k = 3; k >= 1; k--) begin
        if (set[k-1]) begin
          serve(2'(k), int'($urandom_range(0, Tmo + 1)), ($urandom_range(0, 3) == 0),
                (k == 2) ? dw : 1'b0, cyc);
          if (k == 2) data_write = dw;
        end
      end
      @(negedge clk);
      chk_quiet("rand_idle");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
